net_div_ctrl: RTL and testbench

NET_DIV_CTRL -- requirements
Module: net_div_ctrl

---
 rtl/net_div_ctrl.sv | 148 ++++++++++++++
 tb/tb_net_div_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_div_ctrl.sv
// Request/result front end for a pipelined divider: registers operands, launches the
// divider, short-circuits divide-by-zero, bounds the wait with a timeout, holds the result.
module net_div_ctrl #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [DW-1:0] req_a_i,
    input  logic [DW-1:0] req_b_i,
    output logic          div_start_o,
    output logic [DW-1:0] div_a_o,
    output logic [DW-1:0] div_b_o,
    input  logic          div_ready_i,
    input  logic          div_end_i,
    input  logic [DW-1:0] div_quotient_i,
    input  logic [DW-1:0] div_remainder_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [DW-1:0] res_quotient_o,
    output logic [DW-1:0] res_remainder_o,
    output logic          res_dz_o,
    output logic          res_err_o,
    output logic          busy_o,
    output logic [1:0]    dbg_state_o
);

    // Handshakes: a transfer occurs on the rising edge where valid and ready are both high;
    // ready never depends on valid, and a presented result holds until it is taken.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          err_q, err_d;
    logic          start;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        err_d   = err_q;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (req_b_i != '0) begin
                        a_d     = req_a_i;
                        b_d     = req_b_i;
                        state_d = S_ISSUE;
                    end else begin
                        // Divide-by-zero never reaches the divider.
                        quo_d   = '1;
                        rem_d   = req_a_i;
                        dz_d    = 1'b1;
                        err_d   = 1'b0;
                        state_d = S_RESULT;
                    end
                end
            end
            S_ISSUE: begin
                if (div_ready_i) begin
                    start   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A completion in the last allowed cycle beats the timeout.
                if (div_end_i) begin
                    quo_d   = div_quotient_i;
                    rem_d   = div_remainder_i;
                    dz_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_RESULT;
                end else if (cnt_q == TO_LAST) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    dz_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESULT: begin
                if (res_ready_i) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    dz_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign busy_o          = (state_q != S_IDLE);
    assign res_valid_o     = (state_q == S_RESULT);
    assign div_start_o     = start;
    assign div_a_o         = a_q;
    assign div_b_o         = b_q;
    assign res_quotient_o  = quo_q;
    assign res_remainder_o = rem_q;
    assign res_dz_o        = dz_q;
    assign res_err_o       = err_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_net_div_ctrl.sv
// Directed bench for net_div_ctrl: a behavioural divider model answers launches, a
// scoreboard queue holds the expected result of every request that should complete.
module tb_net_div_ctrl;

    localparam int DW      = 32;
    localparam int TIMEOUT = 64;
    localparam int RW      = 2 * DW + 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [DW-1:0] req_a_i;
    logic [DW-1:0] req_b_i;
    logic          div_start_o;
    logic [DW-1:0] div_a_o;
    logic [DW-1:0] div_b_o;
    logic          div_ready_i;
    logic          div_end_i = 1'b0;
    logic [DW-1:0] div_quotient_i = '0;
    logic [DW-1:0] div_remainder_i = '0;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [DW-1:0] res_quotient_o;
    logic [DW-1:0] res_remainder_o;
    logic          res_dz_o;
    logic          res_err_o;
    logic          busy_o;
    logic [1:0]    dbg_state_o;

    net_div_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_a_i         (req_a_i),
        .req_b_i         (req_b_i),
        .div_start_o     (div_start_o),
        .div_a_o         (div_a_o),
        .div_b_o         (div_b_o),
        .div_ready_i     (div_ready_i),
        .div_end_i       (div_end_i),
        .div_quotient_i  (div_quotient_i),
        .div_remainder_i (div_remainder_i),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .res_quotient_o  (res_quotient_o),
        .res_remainder_o (res_remainder_o),
        .res_dz_o        (res_dz_o),
        .res_err_o       (res_err_o),
        .busy_o          (busy_o),
        .dbg_state_o     (dbg_state_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    // ---------------- check bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- divider model ----------------
    int div_lat   = 0;   // 0 means the divider never answers
    int start_cnt = 0;
    int start_cyc = 0;

    always @(negedge clk_i) if (div_start_o) start_cnt++;

    always begin : divider_model
        logic [DW-1:0] ma, mb;
        int ml;
        @(negedge clk_i);
        if (div_start_o && !rst_i) begin
            start_cyc = cyc_cnt;
            ma = div_a_o;
            mb = div_b_o;
            ml = div_lat;
            if (ml > 0) begin
                repeat (ml) @(posedge clk_i);
                #1;
                div_end_i       = 1'b1;
                div_quotient_i  = ma / mb;
                div_remainder_i = ma % mb;
                @(posedge clk_i);
                #1;
                div_end_i       = 1'b0;
                div_quotient_i  = '0;
                div_remainder_i = '0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];

    task automatic expect_res(input logic [DW-1:0] q, input logic [DW-1:0] r,
                              input logic dz, input logic err);
        exp_q.push_back({q, r, dz, err});
    endtask

    always @(negedge clk_i) begin : monitor
        logic [RW-1:0] e;
        if (!rst_i && res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got q=%0h r=%0h with empty queue",
                         res_quotient_o, res_remainder_o);
            end else begin
                e = exp_q.pop_front();
                chk("res_quotient",  64'(res_quotient_o),  64'(e[RW-1 -: DW]));
                chk("res_remainder", 64'(res_remainder_o), 64'(e[DW+1 -: DW]));
                chk("res_dz",        64'(res_dz_o),        64'(e[1]));
                chk("res_err",       64'(res_err_o),       64'(e[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output int acc, output int nw);
        nw          = 0;
        req_valid_i = 1'b1;
        req_a_i     = a;
        req_b_i     = b;
        @(negedge clk_i);
        while (!req_ready_o && nw < 100) begin
            @(negedge clk_i);
            nw++;
        end
        chk("req_ready_at_accept", 64'(req_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        acc         = cyc_cnt;
        req_valid_i = 1'b0;
        req_a_i     = '0;
        req_b_i     = '0;
    endtask

    task automatic wait_valid(output int vc);
        int n = 0;
        @(negedge clk_i);
        while (!res_valid_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        chk("res_valid_seen", 64'(res_valid_o), 64'd1);
        vc = cyc_cnt;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int acc, nw, vc, s0, bad;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_a_i     = '0;
        req_b_i     = '0;
        div_ready_i = 1'b1;
        res_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_busy",      64'(busy_o),      64'd0);
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_div_start", 64'(div_start_o), 64'd0);
        chk("rst_div_a",     64'(div_a_o),     64'd0);
        chk("rst_res_q",     64'(res_quotient_o), 64'd0);
        chk("rst_state",     64'(dbg_state_o), 64'd0);
        next_cycle();
        rst_i = 1'b0;

        // A=100, B=7, divider answers 40 cycles after start; first edge after reset accepts.
        expect_res(32'd14, 32'd2, 1'b0, 1'b0);
        div_lat = 40;
        s0 = start_cnt;
        send(32'd100, 32'd7, acc, nw);
        chk("first_accept_wait", 64'(nw), 64'd0);
        wait_valid(vc);
        chk("lat_100_7", 64'(vc - acc + 1), 64'd42);
        next_cycle();
        chk("start_pulses_100_7", 64'(start_cnt - s0), 64'd1);
        @(negedge clk_i);
        chk("idle_req_ready", 64'(req_ready_o), 64'd1);
        chk("idle_busy",      64'(busy_o),      64'd0);
        chk("idle_res_q_clr", 64'(res_quotient_o), 64'd0);
        chk("idle_res_r_clr", 64'(res_remainder_o), 64'd0);
        next_cycle();

        // Divide-by-zero short-circuit.
        expect_res(32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1'b0);
        s0 = start_cnt;
        send(32'hDEAD_BEEF, 32'd0, acc, nw);
        wait_valid(vc);
        chk("lat_dz", 64'(vc - acc + 1), 64'd1);
        next_cycle();
        chk("start_pulses_dz", 64'(start_cnt - s0), 64'd0);

        // Divider busy for 5 cycles; 60-cycle answer must not time out.
        expect_res(32'd100, 32'd0, 1'b0, 1'b0);
        div_lat     = 60;
        div_ready_i = 1'b0;
        send(32'd1000, 32'd10, acc, nw);
        repeat (5) @(posedge clk_i);
        #1;
        div_ready_i = 1'b1;
        wait_valid(vc);
        chk("stall_start_delay", 64'(start_cyc - acc), 64'd5);
        chk("lat_stall", 64'(vc - acc + 1), 64'd67);
        next_cycle();

        // Divider never ends.
        expect_res(32'd0, 32'd0, 1'b0, 1'b1);
        div_lat = 0;
        send(32'd55, 32'd5, acc, nw);
        wait_valid(vc);
        chk("timeout_from_start", 64'(vc - start_cyc), 64'(TIMEOUT + 1));
        next_cycle();

        // Completion on the last allowed WAIT cycle wins over the timeout.
        expect_res(32'd16, 32'd2, 1'b0, 1'b0);
        div_lat = TIMEOUT;
        send(32'd50, 32'd3, acc, nw);
        wait_valid(vc);
        chk("lat_coincide", 64'(vc - acc + 1), 64'(TIMEOUT + 2));
        next_cycle();

        // Completion one cycle too late: timeout, the late div_end_i is ignored.
        expect_res(32'd0, 32'd0, 1'b0, 1'b1);
        div_lat = TIMEOUT + 1;
        send(32'd50, 32'd3, acc, nw);
        wait_valid(vc);
        chk("lat_late_end", 64'(vc - acc + 1), 64'(TIMEOUT + 2));
        next_cycle();
        repeat (3) next_cycle();

        // Result held for 10 cycles, then back-to-back request.
        expect_res(32'd9, 32'd0, 1'b0, 1'b0);
        res_ready_i = 1'b0;
        div_lat = 2;
        send(32'd81, 32'd9, acc, nw);
        wait_valid(vc);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk_i);
            chk("hold_valid",     64'(res_valid_o),     64'd1);
            chk("hold_q",         64'(res_quotient_o),  64'd9);
            chk("hold_r",         64'(res_remainder_o), 64'd0);
            chk("hold_req_ready", 64'(req_ready_o),     64'd0);
            chk("hold_busy",      64'(busy_o),          64'd1);
        end
        next_cycle();
        res_ready_i = 1'b1;
        expect_res(32'd30, 32'd10, 1'b0, 1'b0);
        div_lat = 5;
        send(32'd1000, 32'd33, acc, nw);
        chk("b2b_accept_wait", 64'(nw), 64'd1);
        wait_valid(vc);
        chk("lat_b2b", 64'(vc - acc + 1), 64'd7);
        next_cycle();

        // Reset mid-WAIT, stray div_end_i afterwards, then a clean operation.
        div_lat = 20;
        send(32'd100, 32'd7, acc, nw);
        repeat (5) next_cycle();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_req_ready", 64'(req_ready_o), 64'd1);
        chk("midrst_busy",      64'(busy_o),      64'd0);
        chk("midrst_div_a",     64'(div_a_o),     64'd0);
        chk("midrst_div_b",     64'(div_b_o),     64'd0);
        next_cycle();
        rst_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (res_valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        chk("stray_end_ignored_cycles", 64'(bad), 64'd0);
        next_cycle();
        expect_res(32'd25, 32'd0, 1'b0, 1'b0);
        div_lat = 3;
        send(32'd200, 32'd8, acc, nw);
        wait_valid(vc);
        chk("lat_after_rst", 64'(vc - acc + 1), 64'd5);
        next_cycle();

        repeat (5) next_cycle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
